toast_scoreboard: RTL and testbench

TOAST_SCOREBOARD -- requirements
Module: toast_scoreboard

---
 rtl/toast_scoreboard.sv | 141 ++++++++++++++
 tb/tb_toast_scoreboard.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/toast_scoreboard.sv
// -----------------------------------------------------------------------------
// toast_scoreboard
//   Register scoreboard for an in-order pipeline. It tracks long-latency
//   writes (loads, multicycle ops) that are still in flight. It also stalls
//   the ID stage on these hazards:
//     - a RAW hazard on rs1/rs2
//     - a WAW hazard on rd
//     - running out of in-flight capacity
//   A write-back that retires in the same cycle is bypassed, so it does not
//   cause a stall.
//
// Ports
//   Clk, Reset          clock, asynchronous active-high reset
//   ID_issue_i          ID instruction wants to advance to EX
//   ID_long_lat_i       ID instruction is long-latency (not forwardable)
//   ID_rd_wr_en_i       ID instruction writes rd
//   ID_rd_addr_i        ID destination register
//   ID_rs1_addr_i       ID source register 1
//   ID_rs2_addr_i       ID source register 2
//   WB_done_i           a long-latency result retires this cycle
//   WB_rd_addr_i        register retired by WB_done_i
//   flush_i             discard all pending marks
//   stall_o             hold IF/ID, bubble into EX (combinational)
//   stall_rs1_o         rs1 hazard term (combinational)
//   stall_rs2_o         rs2 hazard term (combinational)
//   busy_vec_o          per-register pending bits (registered, bit 0 always 0)
//   outstanding_o       number of in-flight long-latency writes (registered)
//   full_o              outstanding_o == MAX_OUTSTANDING (registered)
//   error_o             sticky: a write-back hit a register that was not busy
// -----------------------------------------------------------------------------
module toast_scoreboard #(
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int MAX_OUTSTANDING    = 4
) (
    input  logic                                Clk,
    input  logic                                Reset,
    input  logic                                ID_issue_i,
    input  logic                                ID_long_lat_i,
    input  logic                                ID_rd_wr_en_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0]       ID_rd_addr_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0]       ID_rs1_addr_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0]       ID_rs2_addr_i,
    input  logic                                WB_done_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0]       WB_rd_addr_i,
    input  logic                                flush_i,
    output logic                                stall_o,
    output logic                                stall_rs1_o,
    output logic                                stall_rs2_o,
    output logic [2**REGFILE_ADDR_WIDTH-1:0]    busy_vec_o,
    output logic [3:0]                          outstanding_o,
    output logic                                full_o,
    output logic                                error_o
);

    localparam int NREG = 2**REGFILE_ADDR_WIDTH;
    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    logic [NREG-1:0] busy_q, busy_d;
    logic [NREG-1:0] clr_mask, set_mask, eff_busy;
    logic [3:0]      cnt_q, cnt_d;
    logic            full_q, full_d;
    logic            err_q, err_d;

    logic            wb_busy, clr, set;
    logic            rs1_haz, rs2_haz, waw_haz, cap_haz;
    logic            long_wr, spurious_wb;

    // Hazard and clear/set decode.
    always_comb begin
        wb_busy     = busy_q[WB_rd_addr_i];
        clr         = WB_done_i & (WB_rd_addr_i != '0) & wb_busy & ~flush_i;
        spurious_wb = WB_done_i & ~flush_i & (WB_rd_addr_i != '0) & ~wb_busy;

        clr_mask = '0;
        if (clr) begin
            clr_mask[WB_rd_addr_i] = 1'b1;
        end
        // A register that retires this cycle is already free for hazard checks.
        eff_busy = busy_q & ~clr_mask;

        long_wr = ID_long_lat_i & ID_rd_wr_en_i;
        rs1_haz = eff_busy[ID_rs1_addr_i] & (ID_rs1_addr_i != '0);
        rs2_haz = eff_busy[ID_rs2_addr_i] & (ID_rs2_addr_i != '0);
        waw_haz = long_wr & eff_busy[ID_rd_addr_i] & (ID_rd_addr_i != '0);
        // A retire in the same cycle frees a slot, so a full scoreboard can still accept.
        cap_haz = long_wr & full_q & ~clr;

        stall_rs1_o = rs1_haz;
        stall_rs2_o = rs2_haz;
        stall_o     = ID_issue_i & ~flush_i & (rs1_haz | rs2_haz | waw_haz | cap_haz);

        set = ID_issue_i & ~stall_o & long_wr & (ID_rd_addr_i != '0) & ~flush_i;

        set_mask = '0;
        if (set) begin
            set_mask[ID_rd_addr_i] = 1'b1;
        end
    end

    // Next-state computation.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        err_d  = err_q | spurious_wb;

        if (flush_i) begin
            busy_d = '0;
            cnt_d  = '0;
        end else begin
            // Apply the set after the clear, so a set/clear on the same register leaves it busy.
            busy_d = (busy_q & ~clr_mask) | set_mask;
            unique case ({set, clr})
                2'b10:   if (cnt_q < MAX_CNT) cnt_d = cnt_q + 4'd1;
                2'b01:   if (cnt_q != '0)     cnt_d = cnt_q - 4'd1;
                default: cnt_d = cnt_q;
            endcase
        end
        busy_d[0] = 1'b0;
        full_d    = (cnt_d == MAX_CNT);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
            err_q  <= err_d;
        end
    end

    assign busy_vec_o    = busy_q;
    assign outstanding_o = cnt_q;
    assign full_o        = full_q;
    assign error_o       = err_q;

endmodule

// File: tb/tb_toast_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_toast_scoreboard
//   Self-checking bench for toast_scoreboard. The bench keeps a reference
//   model built from a set of pending registers. In that model, the
//   in-flight count is the population of the set and "full" is derived from
//   it. Every cycle, all outputs are compared against the model. Directed
//   scenarios also pin several values to hand-computed literals. They are
//   followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_toast_scoreboard;

    localparam int AW   = 5;
    localparam int NREG = 2**AW;
    localparam int MAXO = 4;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            ID_issue_i, ID_long_lat_i, ID_rd_wr_en_i;
    logic [AW-1:0]   ID_rd_addr_i, ID_rs1_addr_i, ID_rs2_addr_i;
    logic            WB_done_i;
    logic [AW-1:0]   WB_rd_addr_i;
    logic            flush_i;
    logic            stall_o, stall_rs1_o, stall_rs2_o;
    logic [NREG-1:0] busy_vec_o;
    logic [3:0]      outstanding_o;
    logic            full_o, error_o;

    always #5 Clk = ~Clk;

    toast_scoreboard #(
        .REGFILE_ADDR_WIDTH(AW),
        .MAX_OUTSTANDING   (MAXO)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ID_issue_i   (ID_issue_i),
        .ID_long_lat_i(ID_long_lat_i),
        .ID_rd_wr_en_i(ID_rd_wr_en_i),
        .ID_rd_addr_i (ID_rd_addr_i),
        .ID_rs1_addr_i(ID_rs1_addr_i),
        .ID_rs2_addr_i(ID_rs2_addr_i),
        .WB_done_i    (WB_done_i),
        .WB_rd_addr_i (WB_rd_addr_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .stall_rs1_o  (stall_rs1_o),
        .stall_rs2_o  (stall_rs2_o),
        .busy_vec_o   (busy_vec_o),
        .outstanding_o(outstanding_o),
        .full_o       (full_o),
        .error_o      (error_o)
    );

    int passed = 0;
    int total  = 0;

    // Reference state: which registers have a long-latency write pending.
    bit mbusy [NREG];
    bit merr;
    bit nbusy [NREG];
    bit nerr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int mcount();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += mbusy[i] ? 1 : 0;
        return n;
    endfunction

    function automatic bit mclr();
        return WB_done_i && WB_rd_addr_i != 0 && mbusy[WB_rd_addr_i] && !flush_i;
    endfunction

    // A register counts as pending unless it is x0 or it retires right now.
    function automatic bit mpending(input int r);
        return r != 0 && mbusy[r] && !(mclr() && int'(WB_rd_addr_i) == r);
    endfunction

    function automatic bit mstall();
        bit lw  = ID_long_lat_i && ID_rd_wr_en_i;
        bit haz = mpending(int'(ID_rs1_addr_i)) || mpending(int'(ID_rs2_addr_i))
               || (lw && mpending(int'(ID_rd_addr_i)))
               || (lw && mcount() == MAXO && !mclr());
        return ID_issue_i && !flush_i && haz;
    endfunction

    task automatic compare_all();
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = mbusy[i];
        check("busy_vec",    busy_vec_o,    v);
        check("outstanding", outstanding_o, mcount());
        check("full",        full_o,        mcount() == MAXO);
        check("error",       error_o,       merr);
        check("stall",       stall_o,       mstall());
        check("stall_rs1",   stall_rs1_o,   mpending(int'(ID_rs1_addr_i)));
        check("stall_rs2",   stall_rs2_o,   mpending(int'(ID_rs2_addr_i)));
    endtask

    task automatic model_next();
        bit c = mclr();
        bit s = ID_issue_i && !mstall() && ID_long_lat_i && ID_rd_wr_en_i
             && ID_rd_addr_i != 0 && !flush_i;
        nbusy = mbusy;
        nerr  = merr;
        if (flush_i) begin
            for (int i = 0; i < NREG; i++) nbusy[i] = 1'b0;
        end else begin
            if (c) nbusy[WB_rd_addr_i] = 1'b0;
            if (s) nbusy[ID_rd_addr_i] = 1'b1;
            if (WB_done_i && WB_rd_addr_i != 0 && !mbusy[WB_rd_addr_i]) nerr = 1'b1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) mbusy[i] = 1'b0;
        merr = 1'b0;
    endtask

    // Called just after a negedge with the inputs already driven.
    task automatic step();
        #1 compare_all();
        model_next();
        @(posedge Clk);
        mbusy = nbusy;
        merr  = nerr;
        @(negedge Clk);
    endtask

    task automatic drive(input bit iss, input bit lng, input bit wr, input int rd,
                         input int rs1, input int rs2, input bit wb, input int wbrd,
                         input bit fl);
        ID_issue_i    = iss;
        ID_long_lat_i = lng;
        ID_rd_wr_en_i = wr;
        ID_rd_addr_i  = AW'(rd);
        ID_rs1_addr_i = AW'(rs1);
        ID_rs2_addr_i = AW'(rs2);
        WB_done_i     = wb;
        WB_rd_addr_i  = AW'(wbrd);
        flush_i       = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1 model_reset();
        check("reset_busy",  busy_vec_o,    0);
        check("reset_out",   outstanding_o, 0);
        check("reset_err",   error_o,       0);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        idle();
        model_reset();
        #1;
        check("rst_stall", stall_o, 0);
        check("rst_full",  full_o,  0);
        @(negedge Clk);
        do_reset();

        // Load-use hazard, released by the same-cycle write-back bypass.
        drive(1, 1, 1, 5, 0, 0, 0, 0, 0); step();
        check("lu_busy", busy_vec_o, 32'h20);
        check("lu_out",  outstanding_o, 1);
        drive(1, 0, 1, 8, 5, 0, 0, 0, 0);
        #1 check("lu_stall", stall_o, 1);
        check("lu_stall_rs1", stall_rs1_o, 1);
        step(); step();
        drive(1, 0, 1, 8, 5, 0, 1, 5, 0);
        #1 check("lu_bypass", stall_o, 0);
        step();
        check("lu_busy_clr", busy_vec_o, 0);

        // Capacity limit, and retire-while-full.
        for (int r = 1; r <= 4; r++) begin
            drive(1, 1, 1, r, 0, 0, 0, 0, 0); step();
        end
        check("cap_out",  outstanding_o, 4);
        check("cap_full", full_o, 1);
        check("cap_busy", busy_vec_o, 32'h1E);
        drive(1, 1, 1, 10, 0, 0, 0, 0, 0);
        #1 check("cap_stall", stall_o, 1);
        step();
        drive(1, 1, 1, 10, 0, 0, 1, 1, 0);
        #1 check("cap_bypass", stall_o, 0);
        step();
        check("cap_out2",  outstanding_o, 4);
        check("cap_busy2", busy_vec_o, 32'h41C);

        // Set and clear of the same register in one cycle.
        drive(0, 0, 0, 0, 0, 0, 1, 2, 0); step();
        drive(1, 1, 1, 7, 0, 0, 0, 0, 0); step();
        check("same_busy0", busy_vec_o, 32'h498);
        drive(1, 1, 1, 7, 0, 0, 1, 7, 0);
        #1 check("same_stall", stall_o, 0);
        step();
        check("same_busy", busy_vec_o, 32'h498);
        check("same_out",  outstanding_o, 4);

        // Flush with a simultaneous issue and write-back.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
        drive(1, 1, 1, 3, 0, 0, 0, 0, 0); step();
        drive(1, 1, 1, 6, 0, 0, 0, 0, 0); step();
        check("fl_busy0", busy_vec_o, 32'h48);
        drive(1, 1, 1, 9, 3, 0, 1, 3, 1);
        #1 check("fl_stall", stall_o, 0);
        step();
        check("fl_busy", busy_vec_o, 0);
        check("fl_out",  outstanding_o, 0);
        check("fl_err",  error_o, 0);

        // x0 is never tracked and write-backs to it are ignored.
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0); step();
        check("x0_busy", busy_vec_o, 0);
        check("x0_out",  outstanding_o, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); step();
        check("x0_err", error_o, 0);

        // Asynchronous reset in the middle of a stall.
        drive(1, 1, 1, 5, 0, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 5, 0, 0, 0, 0);
        #1 check("ar_stall_pre", stall_o, 1);
        #1 Reset = 1'b1;
        #1 check("ar_stall", stall_o, 0);
        check("ar_busy", busy_vec_o, 0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
        idle();

        // Spurious write-back: error is sticky until reset.
        drive(0, 0, 0, 0, 0, 0, 1, 9, 0); step();
        check("sp_err", error_o, 1);
        idle(); step(); step();
        check("sp_err_hold", error_o, 1);
        do_reset();

        // Randomized traffic over a small register window.
        for (int i = 0; i < 3000; i++) begin
            int start, pick;
            bit found;
            pick  = 0;
            found = 0;
            start = $urandom_range(7);
            for (int k = 0; k < 8; k++) begin
                int idx = (start + k) % 8;
                if (!found && idx != 0 && mbusy[idx]) begin
                    pick  = idx;
                    found = 1;
                end
            end
            if (i > 2500 && $urandom_range(31) == 0) pick = $urandom_range(7);
            drive($urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(4) != 0,
                  $urandom_range(7), $urandom_range(7), $urandom_range(7),
                  $urandom_range(2) == 0, pick, $urandom_range(39) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
